// File: rtl/axi_dma_burst_reshaper_pkg.sv
// Shared types for the DMA backend front end.
// Page size, FSM states and burst request bundles.
package axi_dma_pkg;

  localparam int unsigned PageSize = 4096;

  localparam int unsigned DefAddrWidth = 64;
  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefStrbWidth = DefDataWidth / 8;
  localparam int unsigned DefOffsetWidth = $clog2(DefStrbWidth);

  typedef enum logic {
    Idle,
    Busy
  } state_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] src_addr;
    logic [DefAddrWidth-1:0] dst_addr;
    logic [DefAddrWidth-1:0] num_bytes;
  } burst_req_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0]   addr;
    logic [7:0]                len;
    logic [DefOffsetWidth-1:0] offset;
    logic [DefOffsetWidth-1:0] tailer;
    logic [DefOffsetWidth-1:0] shift;
    logic                      last;
  } r_req_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0]   addr;
    logic [7:0]                len;
    logic [DefOffsetWidth-1:0] offset;
    logic [DefOffsetWidth-1:0] tailer;
    logic [7:0]                num_beats;
    logic                      is_single;
    logic                      last;
  } w_req_t;

endpackage

// File: rtl/axi_dma_burst_reshaper_if.sv
// Transfer request plus read/write burst channels of the reshaper.
// master = request issuer / burst consumer, slave = the reshaper.
interface axi_dma_burst_reshaper_if #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 64
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffsetWidth = $clog2(StrbWidth);

  logic                   burst_req_valid;
  logic                   burst_req_ready;
  logic [AddrWidth-1:0]   src_addr;
  logic [AddrWidth-1:0]   dst_addr;
  logic [AddrWidth-1:0]   num_bytes;

  logic                   r_req_valid;
  logic                   r_req_ready;
  logic [AddrWidth-1:0]   r_addr;
  logic [7:0]             r_len;
  logic [OffsetWidth-1:0] r_offset;
  logic [OffsetWidth-1:0] r_tailer;
  logic [OffsetWidth-1:0] r_shift;
  logic                   r_last;

  logic                   w_req_valid;
  logic                   w_req_ready;
  logic [AddrWidth-1:0]   w_addr;
  logic [7:0]             w_len;
  logic [OffsetWidth-1:0] w_offset;
  logic [OffsetWidth-1:0] w_tailer;
  logic [7:0]             w_num_beats;
  logic                   w_is_single;
  logic                   w_last;

  modport master (
    output burst_req_valid, src_addr, dst_addr, num_bytes,
    output r_req_ready, w_req_ready,
    input  burst_req_ready,
    input  r_req_valid, r_addr, r_len, r_offset, r_tailer,
    input  r_shift, r_last,
    input  w_req_valid, w_addr, w_len, w_offset, w_tailer,
    input  w_num_beats, w_is_single, w_last
  );

  modport slave (
    input  burst_req_valid, src_addr, dst_addr, num_bytes,
    input  r_req_ready, w_req_ready,
    output burst_req_ready,
    output r_req_valid, r_addr, r_len, r_offset, r_tailer,
    output r_shift, r_last,
    output w_req_valid, w_addr, w_len, w_offset, w_tailer,
    output w_num_beats, w_is_single, w_last
  );

endinterface

// File: rtl/axi_dma_burst_reshaper_splitter.sv
// One-sided burst splitter: walks an address range in legal INCR
// bursts that never cross a page or exceed the max burst size.
module axi_dma_burst_splitter
  import axi_dma_pkg::*;
#(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned StrbWidth   = 8,
  parameter int unsigned OffsetWidth = 3,
  parameter int unsigned MaxBeats    = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start,
  input  logic [AddrWidth-1:0]   start_addr,
  input  logic [AddrWidth-1:0]   start_bytes,
  output logic                   valid,
  input  logic                   ready,
  output logic [AddrWidth-1:0]   addr,
  output logic [7:0]             len,
  output logic [OffsetWidth-1:0] offset,
  output logic [OffsetWidth-1:0] tailer,
  output logic                   last
);

  localparam int unsigned W = AddrWidth + 1;

  logic [AddrWidth-1:0] a;
  logic [AddrWidth-1:0] rem;
  logic [AddrWidth-1:0] cur_a;
  logic [AddrWidth-1:0] cur_rem;
  logic [W-1:0]         to_page;
  logic [W-1:0]         to_max;
  logic [W-1:0]         bytes;
  logic [W-1:0]         end_a;
  logic [W-1:0]         rem_left;
  logic [W-1:0]         beats;
  logic                 load;

  // a/rem hold the position after the burst currently presented
  assign load = start || (valid && ready && !last);

  always_comb begin
    cur_a    = start ? start_addr : a;
    cur_rem  = start ? start_bytes : rem;
    to_page  = W'(PageSize) - W'(cur_a[11:0]);
    to_max   = W'(MaxBeats * StrbWidth)
             - W'(cur_a[OffsetWidth-1:0]);
    bytes    = {1'b0, cur_rem};
    if (to_page < bytes) bytes = to_page;
    if (to_max < bytes) bytes = to_max;
    end_a    = {1'b0, cur_a} + bytes;
    rem_left = {1'b0, cur_rem} - bytes;
    beats    = (W'(cur_a[OffsetWidth-1:0]) + bytes
             + W'(StrbWidth - 1)) >> OffsetWidth;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid  <= 1'b0;
      addr   <= '0;
      len    <= '0;
      offset <= '0;
      tailer <= '0;
      last   <= 1'b0;
      a      <= '0;
      rem    <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      addr   <= cur_a;
      len    <= 8'(beats - W'(1));
      offset <= cur_a[OffsetWidth-1:0];
      tailer <= OffsetWidth'(end_a);
      last   <= (bytes == {1'b0, cur_rem});
      a      <= AddrWidth'(end_a);
      rem    <= AddrWidth'(rem_left);
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_dma_burst_reshaper.sv
// DMA backend front stage: accepts a linear transfer and drives
// independent read and write burst splitters.
module axi_dma_burst_reshaper
  import axi_dma_pkg::*;
#(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned MaxBeats    = 256,
  parameter int unsigned StrbWidth   = DataWidth / 8,
  parameter int unsigned OffsetWidth = $clog2(StrbWidth)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  axi_dma_burst_reshaper_if.slave bus,
  output logic                    busy_o
);

  state_e                 state;
  logic                   req_ready;
  logic [OffsetWidth-1:0] shift;
  logic                   start;
  logic                   r_fin;
  logic                   w_fin;

  assign start = (state == Idle) && bus.burst_req_valid
              && (bus.num_bytes != '0);

  // a side is finished once idle or handing off its last burst now
  assign r_fin = !bus.r_req_valid
              || (bus.r_req_ready && bus.r_last);
  assign w_fin = !bus.w_req_valid
              || (bus.w_req_ready && bus.w_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= Idle;
      req_ready <= 1'b1;
      busy_o    <= 1'b0;
      shift     <= '0;
    end else begin
      unique case (state)
        Idle: begin
          if (start) begin
            state     <= Busy;
            req_ready <= 1'b0;
            busy_o    <= 1'b1;
            shift     <= OffsetWidth'(bus.src_addr
                       - bus.dst_addr);
          end
        end
        Busy: begin
          if (r_fin && w_fin) begin
            state     <= Idle;
            req_ready <= 1'b1;
            busy_o    <= 1'b0;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

  assign bus.burst_req_ready = req_ready;
  assign bus.r_shift         = shift;
  assign bus.w_num_beats     = bus.w_len;
  assign bus.w_is_single     = (bus.w_len == 8'd0);

  axi_dma_burst_splitter #(
    .AddrWidth  (AddrWidth),
    .StrbWidth  (StrbWidth),
    .OffsetWidth(OffsetWidth),
    .MaxBeats   (MaxBeats)
  ) i_rd (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start      (start),
    .start_addr (bus.src_addr),
    .start_bytes(bus.num_bytes),
    .valid      (bus.r_req_valid),
    .ready      (bus.r_req_ready),
    .addr       (bus.r_addr),
    .len        (bus.r_len),
    .offset     (bus.r_offset),
    .tailer     (bus.r_tailer),
    .last       (bus.r_last)
  );

  axi_dma_burst_splitter #(
    .AddrWidth  (AddrWidth),
    .StrbWidth  (StrbWidth),
    .OffsetWidth(OffsetWidth),
    .MaxBeats   (MaxBeats)
  ) i_wr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start      (start),
    .start_addr (bus.dst_addr),
    .start_bytes(bus.num_bytes),
    .valid      (bus.w_req_valid),
    .ready      (bus.w_req_ready),
    .addr       (bus.w_addr),
    .len        (bus.w_len),
    .offset     (bus.w_offset),
    .tailer     (bus.w_tailer),
    .last       (bus.w_last)
  );

endmodule

// File: doc/axi_dma_burst_reshaper.md
# axi_dma_burst_reshaper

Front stage of the AXI DMA backend. It accepts one linear transfer request (source address, destination address, byte count) and splits it into legal AXI4 INCR bursts. Splitting is done separately for the read side and the write side, and every burst respects 4 KiB page boundaries and the maximum burst length. For each burst it emits an AR/AW request, plus the per-burst alignment fields (offset, tailer, shift, beat count, single flag) consumed by the data path stage downstream.

## Interface
- DataWidth, 64: AXI data width in bits, power of two, ≥ 16.
- AddrWidth, 64: address and byte-count width.
- MaxBeats, 256: maximum beats per burst, power of two, ≤ 256.
- StrbWidth, DataWidth/8: derived, do not override.
- OffsetWidth, $clog2(StrbWidth): derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- burst_req_valid_i / burst_req_ready_o  in/out  1  transfer request handshake.
- src_addr_i, dst_addr_i  in  AddrWidth  transfer start addresses.
- num_bytes_i  in  AddrWidth  transfer length in bytes.
- r_req_valid_o / r_req_ready_i  out/in  1  read burst handshake.
- r_addr_o  out  AddrWidth  AR address.
- r_len_o  out  8  AR len (beats − 1).
- r_offset_o, r_tailer_o, r_shift_o  out  OffsetWidth  read alignment fields.
- r_last_o  out  1  final read burst of the transfer.
- w_req_valid_o / w_req_ready_i  out/in  1  write burst handshake.
- w_addr_o  out  AddrWidth  AW address.
- w_len_o  out  8  AW len.
- w_offset_o, w_tailer_o  out  OffsetWidth  write alignment fields.
- w_num_beats_o  out  8  equals w_len_o.
- w_is_single_o  out  1  asserted when w_len_o == 0.
- w_last_o  out  1  final write burst of the transfer.
- busy_o  out  1  a transfer is in progress.

## Operation
- Top FSM has two states, IDLE and BUSY.
- IDLE: burst_req_ready_o = 1.
  - On handshake with num_bytes_i ≠ 0: latch src_addr, rem_r = num_bytes, dst_addr, rem_w = num_bytes, and shift = (src_addr_i − dst_addr_i)[OffsetWidth−1:0]; go to BUSY.
  - On handshake with num_bytes_i == 0: accept the request, emit nothing, stay in IDLE.
- BUSY: burst_req_ready_o = 0. Return to IDLE in the cycle after both sides have handed off their last burst.
- The read and write sides are independent engines. Each emits bursts at its own pace, with no ordering between sides.
- Per-side burst computation, for current address a and remaining bytes rem:
  - to_page = 4096 − a[11:0].
  - to_max = MaxBeats·StrbWidth − a[OffsetWidth−1:0].
  - bytes = min(rem, to_page, to_max).
  - offset = a[OffsetWidth−1:0].
  - tailer = (a + bytes)[OffsetWidth−1:0]; 0 means the final beat is full.
  - len = ceil((offset + bytes)/StrbWidth) − 1.
  - last = (bytes == rem).
- On a side's handshake: a += bytes and rem −= bytes. When last is handed off, that side is done and its valid drops.
- Bursts after the first start at page- or max-aligned addresses, so their offset is 0.
- r_shift_o is constant for the whole transfer.
- All arithmetic is unsigned. Intermediate sums are AddrWidth+1 bits; no wrap is permitted.

## Timing
- Reset values:
  - burst_req_ready_o = 1.
  - r_req_valid_o = w_req_valid_o = 0.
  - busy_o = 0.
  - All address, length and alignment outputs = 0.
  - FSM in IDLE.
- Latency: request accepted at cycle T → first r_req_valid_o and w_req_valid_o at T+1.
- Throughput: one burst per side per cycle under continuous ready.
- Outputs are driven from registers. Once valid is asserted, all fields stay stable until the handshake.
- Valid never depends combinationally on ready.
- If one side is back-pressured, the other side continues unaffected.
- Reset mid-transfer: everything returns to the reset values immediately; in-flight bursts are dropped.
- The next request is accepted no earlier than the cycle after the final handshake of the slower side.

## Structure
- axi_dma_pkg holds PageSize = 4096 and the packed structs burst_req_t, r_req_t and w_req_t.
- Sub-module axi_dma_burst_splitter (address, remaining-byte counter, min/len/offset/tailer logic, valid/ready) is instantiated twice, once for read and once for write.
- The top level holds the IDLE/BUSY FSM and the shift register.

## Test plan
DataWidth = 64 throughout.
- Aligned transfer: src 0x1000, dst 0x2000, 64 B → one read and one write burst, each len 7, offset 0, tailer 0, last 1; shift 0; w_is_single 0.
- Read page crossing: src 0x0FFC, dst 0x3000, 16 B → read bursts:
  - 0x0FFC: len 0, offset 4, tailer 0.
  - 0x1000: len 1, offset 0, tailer 4, last 1.
  - Write burst: 0x3000, len 1, tailer 0. Shift = 4.
- Max-beat split: src 0x0, dst 0x8000, 4096 B → two bursts per side, at +0x000 and +0x800, each len 255; last set only on the second.
- Back-pressure: same as the first scenario with 1024 B and w_req_ready_i low for 5 cycles →
  - read bursts complete unaffected;
  - write fields stay stable while stalled;
  - burst_req_ready_o stays 0 until the final write handshake, then 1 one cycle later.
- Zero length: num_bytes 0 → no r/w valid ever asserted; burst_req_ready_o still 1 on the next cycle.
- Reset mid-transfer: assert rst_ni low during the second read burst → all outputs at reset values in the same cycle; a new transfer after reset splits correctly.
